// File: rtl/seq_pattern_tx_moore_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_pattern_tx_moore_if                                                  |
// | Request/control and serial-output bundle of the pattern transmitter.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface seq_pattern_tx_moore_if #(
  parameter int PAT_W = 3,
  parameter int GAP_W = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             out;
  logic             out_valid;
  logic             last_bit;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_n, gap, abort,
    input  out, out_valid, last_bit, busy, done
  );

  modport slave (
    input  start, pattern, repeat_n, gap, abort,
    output out, out_valid, last_bit, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/seq_pattern_tx_moore.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_pattern_tx_moore                                                     |
// | Moore FSM sending a latched pattern MSB-first, repeated with idle gaps.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module seq_pattern_tx_moore #(
  parameter int PAT_W = 3,
  parameter int GAP_W = 4,
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  seq_pattern_tx_moore_if.slave bus
);

  localparam int                 c_IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [PAT_W-1:0]   r_pat, w_pat_nxt;
  logic [c_IDX_W-1:0] r_idx, w_idx_nxt;
  logic [CNT_W-1:0]   r_rem, w_rem_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic [GAP_W-1:0]   r_gcnt, w_gcnt_nxt;

  logic r_out, r_valid, r_last, r_busy, r_done;
  logic w_out_nxt, w_valid_nxt, w_last_nxt, w_busy_nxt, w_done_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_idx_nxt   = r_idx;
    w_rem_nxt   = r_rem;
    w_gap_nxt   = r_gap;
    w_gcnt_nxt  = r_gcnt;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.repeat_n != '0) begin
            w_state_nxt = S_SEND;
            w_pat_nxt   = bus.pattern;
            w_rem_nxt   = bus.repeat_n;
            w_gap_nxt   = bus.gap;
            w_idx_nxt   = c_IDX_MAX;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_SEND: begin
        if (bus.abort) begin
          w_state_nxt = S_DONE;
        end else if (r_idx == '0) begin
          // Repeat boundary: the count decides between gap, back-to-back or finish.
          w_rem_nxt = r_rem - CNT_W'(1);
          if (w_rem_nxt == '0) begin
            w_state_nxt = S_DONE;
          end else if (r_gap != '0) begin
            w_state_nxt = S_GAP;
            w_gcnt_nxt  = r_gap;
          end else begin
            w_idx_nxt = c_IDX_MAX;
          end
        end else begin
          w_idx_nxt = r_idx - c_IDX_W'(1);
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          w_state_nxt = S_DONE;
        end else if (r_gcnt == GAP_W'(1)) begin
          w_state_nxt = S_SEND;
          w_idx_nxt   = c_IDX_MAX;
        end else begin
          w_gcnt_nxt = r_gcnt - GAP_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops alongside it.
  always_comb begin
    w_out_nxt   = 1'b0;
    w_valid_nxt = 1'b0;
    w_last_nxt  = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (w_state_nxt)
      S_SEND: begin
        w_out_nxt   = w_pat_nxt[w_idx_nxt];
        w_valid_nxt = 1'b1;
        w_last_nxt  = (w_idx_nxt == '0);
        w_busy_nxt  = 1'b1;
      end
      S_GAP: begin
        w_busy_nxt = 1'b1;
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_idx   <= '0;
      r_rem   <= '0;
      r_gap   <= '0;
      r_gcnt  <= '0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_idx   <= w_idx_nxt;
      r_rem   <= w_rem_nxt;
      r_gap   <= w_gap_nxt;
      r_gcnt  <= w_gcnt_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_valid;
  assign bus.last_bit  = r_last;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx_moore.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_pattern_tx_moore                                                  |
// | Directed and random stimulus against a queue-based transfer model.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_seq_pattern_tx_moore;

  localparam int PAT_W = 3;
  localparam int GAP_W = 4;
  localparam int CNT_W = 8;

  // Output tuple order: {out, out_valid, last_bit, busy, done}
  localparam logic [4:0] c_IDLE = 5'b00000;
  localparam logic [4:0] c_DONE = 5'b00001;
  localparam logic [4:0] c_GAP  = 5'b00010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic en_cmp = 1'b0;

  seq_pattern_tx_moore_if #(.PAT_W(PAT_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) bus ();

  seq_pattern_tx_moore #(.PAT_W(PAT_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] dut_vec();
    return {bus.out, bus.out_valid, bus.last_bit, bus.busy, bus.done};
  endfunction

  // Behavioural model: a transfer is expanded into its full per-cycle output list.
  logic [4:0] q[$];
  logic [4:0] cur = c_IDLE;

  always @(posedge clk) begin
    logic [PAT_W-1:0] p;
    int n;
    int g;
    if (rst) begin
      q.delete();
      cur = c_IDLE;
    end else if (cur[1] && bus.abort) begin
      q.delete();
      cur = c_DONE;
    end else if (q.size() == 0 && cur == c_IDLE && bus.start) begin
      p = bus.pattern;
      n = int'(bus.repeat_n);
      g = int'(bus.gap);
      for (int r = 0; r < n; r++) begin
        for (int b = PAT_W - 1; b >= 0; b--)
          q.push_back({p[b], 1'b1, (b == 0), 1'b1, 1'b0});
        if (r < n - 1)
          for (int k = 0; k < g; k++) q.push_back(c_GAP);
      end
      q.push_back(c_DONE);
      cur = q.pop_front();
    end else if (q.size() != 0) begin
      cur = q.pop_front();
    end else begin
      cur = c_IDLE;
    end
  end

  always @(negedge clk) begin
    if (en_cmp) begin
      checks++;
      if (dut_vec() !== cur) begin
        errors++;
        $display("FAIL model t=%0t dut=%b expected=%b", $time, dut_vec(), cur);
      end
    end
  end

  task automatic chk(input string name, input logic [4:0] lit);
    checks++;
    if (dut_vec() !== lit) begin
      errors++;
      $display("FAIL %s dut=%b expected=%b", name, dut_vec(), lit);
    end
    checks++;
    if (cur !== lit) begin
      errors++;
      $display("FAIL %s_model model=%b expected=%b", name, cur, lit);
    end
  endtask

  task automatic launch(input logic [PAT_W-1:0] p, input int n, input int g);
    @(negedge clk);
    bus.pattern  = p;
    bus.repeat_n = CNT_W'(n);
    bus.gap      = GAP_W'(g);
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int dets;
    logic [2:0] sh;
    int nvalid;
    bus.start = 1'b0; bus.pattern = '0; bus.repeat_n = '0; bus.gap = '0; bus.abort = 1'b0;
    @(posedge clk);
    en_cmp = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset", c_IDLE);
    rst = 1'b0;
    @(negedge clk);

    // 101 once, no gap
    launch(3'b101, 1, 0);
    chk("t1_b0", 5'b11010);
    @(negedge clk); chk("t1_b1", 5'b01010);
    @(negedge clk); chk("t1_b2", 5'b11110);
    @(negedge clk); chk("t1_done", c_DONE);
    @(negedge clk); chk("t1_idle", c_IDLE);

    // 101 twice with a 2-cycle gap
    launch(3'b101, 2, 2);
    chk("t2_c1", 5'b11010);
    @(negedge clk); chk("t2_c2", 5'b01010);
    @(negedge clk); chk("t2_c3", 5'b11110);
    @(negedge clk); chk("t2_c4", c_GAP);
    @(negedge clk); chk("t2_c5", c_GAP);
    @(negedge clk); chk("t2_c6", 5'b11010);
    @(negedge clk); chk("t2_c7", 5'b01010);
    @(negedge clk); chk("t2_c8", 5'b11110);
    @(negedge clk); chk("t2_done", c_DONE);

    // zero repeats
    launch(3'b111, 0, 3);
    chk("t3_done", c_DONE);
    @(negedge clk); chk("t3_idle", c_IDLE);

    // mid-transfer start with a new pattern, then start during DONE
    launch(3'b101, 1, 0);
    bus.start = 1'b1; bus.pattern = 3'b011; bus.repeat_n = 8'd5;
    @(negedge clk); chk("t4_b1", 5'b01010);
    bus.start = 1'b0;
    @(negedge clk); chk("t4_b2", 5'b11110);
    @(negedge clk); chk("t4_done", c_DONE);
    bus.start = 1'b1;
    @(negedge clk); chk("t4_ign", c_IDLE);
    bus.start = 1'b0;
    @(negedge clk); chk("t4_idle", c_IDLE);

    // reset during the second SEND bit
    launch(3'b111, 3, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); chk("t5_rst", c_IDLE);
    rst = 1'b0;
    @(negedge clk); chk("t5_idle", c_IDLE);

    // abort inside the gap
    launch(3'b110, 3, 4);
    repeat (3) @(negedge clk);
    chk("t5_gap", c_GAP);
    bus.abort = 1'b1;
    @(negedge clk); chk("t5_abort", c_DONE);
    bus.abort = 1'b0;
    @(negedge clk); chk("t5_after", c_IDLE);

    // loopback into a 101 detector, back-to-back repeats
    dets = 0; sh = '0; nvalid = 0;
    launch(3'b101, 4, 0);
    for (int i = 0; i < 16; i++) begin
      if (bus.out_valid) begin
        sh = {sh[1:0], bus.out};
        nvalid++;
        if (nvalid >= 3 && sh == 3'b101) dets++;
      end
      @(negedge clk);
    end
    checks++;
    if (dets != 4) begin
      errors++;
      $display("FAIL t6_detects got=%0d expected=4", dets);
    end

    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      bus.start    = ($urandom_range(0, 4) == 0);
      bus.pattern  = PAT_W'($urandom);
      bus.repeat_n = CNT_W'($urandom_range(0, 4));
      bus.gap      = ($urandom_range(0, 9) == 0) ? GAP_W'($urandom_range(0, 15))
                                                 : GAP_W'($urandom_range(0, 2));
      bus.abort    = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    rst = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    repeat (80) @(negedge clk);
    chk("final_idle", c_IDLE);

    en_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
